// File: rtl/uart_rx_frame.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1/2 stop bits,
// 3-sample majority voting, break detection and a valid/ready holding register.
module uart_rx_frame #(
  parameter int DBIT_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  s_tick,
  input  logic                  rx_ready,
  output logic [DBIT_WIDTH-1:0] data_out,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  break_det
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DBIT_WIDTH);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE - 3);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE - 2);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT_WIDTH - 1);
  localparam logic [NW-1:0] N_STOP = NW'(STOP_BITS - 1);
  localparam logic          P_ODD  = 1'(PARITY_ODD);
  localparam logic          P_EN   = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sync_q;
  logic [SW-1:0]           s_q, s_d;
  logic [NW-1:0]           n_q, n_d;
  logic [DBIT_WIDTH-1:0]   sh_q, sh_d;
  logic [1:0]              smp_q, smp_d;
  logic                    par_q, par_d;
  logic                    pfail_q, pfail_d;
  logic                    ffail_q, ffail_d;
  logic [DBIT_WIDTH-1:0]   dout_q, dout_d;
  logic                    vld_q, vld_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    ovr_q, ovr_d;
  logic                    brk_q, brk_d;

  logic rx_s, vote, fail_now, bit_end, in_bit, brk_hit;

  assign rx_s     = sync_q[1];
  assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign fail_now = ffail_q | ~vote;
  assign in_bit   = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
  assign bit_end  = s_tick && (s_q == S_END);
  // A break is an all-zero frame including parity and a failed stop bit.
  assign brk_hit  = (sh_q == '0) && (!P_EN || !par_q) && fail_now;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    smp_d   = smp_q;
    par_d   = par_q;
    pfail_d = pfail_q;
    ffail_d = ffail_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    brk_d   = 1'b0;

    if (vld_q && rx_ready) vld_d = 1'b0;

    if (in_bit && s_tick) begin
      s_d = (s_q == S_END) ? '0 : s_q + 1'b1;
      if (s_q == S_V0) smp_d[0] = rx_s;
      if (s_q == S_V1) smp_d[1] = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (rx_s) state_d = IDLE;
            else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
              ffail_d = 1'b0;
              pfail_d = 1'b0;
              par_d   = 1'b0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d = {vote, sh_q[DBIT_WIDTH-1:1]};
          if (n_q == N_LAST) begin
            n_d     = '0;
            state_d = P_EN ? PARITY : STOP;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_d   = vote;
          pfail_d = (^sh_q) ^ vote ^ P_ODD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (n_q != N_STOP) begin
            ffail_d = fail_now;
            n_d     = n_q + 1'b1;
          end else begin
            n_d = '0;
            if (brk_hit) begin
              state_d = BRK;
              brk_d   = 1'b1;
            end else begin
              state_d = IDLE;
              // A word taken by the host this same clk frees the register.
              if (!vld_q || rx_ready) begin
                dout_d = sh_q;
                perr_d = P_EN & pfail_q;
                ferr_d = fail_now;
                vld_d  = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end
          end
        end
      end
      BRK: begin
        if (s_tick && rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      smp_q   <= '0;
      par_q   <= 1'b0;
      pfail_q <= 1'b0;
      ffail_q <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      smp_q   <= smp_d;
      par_q   <= par_d;
      pfail_q <= pfail_d;
      ffail_q <= ffail_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      brk_q   <= brk_d;
    end
  end

  assign data_out    = dout_q;
  assign rx_valid    = vld_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign break_det   = brk_q;

endmodule
